mmu_dma: RTL and testbench

//  Bus-master DMA engine for the MMU09 SBC: initiator of the CPU-side bus cycles that the MMU/address decoder answers.

---
 rtl/mmu_dma.sv | 176 +++++++++++++++++
 tb/tb_mmu_dma.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_dma.sv
// mmu_dma: MMU09 bus-master DMA engine, programmed through $FEA0-$FEA7 and copying one byte per three E cycles.
// Optional completion interrupt (CTRL b7 enable) is built only when MMU09_DMA_IRQ_EN is defined.
module mmu_dma #(
  parameter int         CNT_W    = 16,
  parameter logic [2:0] REG_BASE = 3'b101
) (
  input  logic        i_eclk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  input  logic        i_kernio,
  input  logic        i_ba,
  input  logic        i_bs,
  output logic        o_halt_n,
  output logic        o_busen,
  output logic [15:0] o_addr,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic        o_rden,
  output logic        o_irq_n
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT, REL} state_t;

  state_t           state, state_nx;
  logic [15:0]      src, dst, cnt_view;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rdbuf, rd_mux;
  logic [2:0]       idx;
  logic             srcinc, dstinc, abort_q, done, aborted, ie;
  logic             sel, reg_wr, reg_rd, ctrl_wr, stat_rd, busy, abort_now;
  logic             unused_addr_bits;

  assign sel       = i_kernio && (i_addr[7:5] == REG_BASE);
  assign idx       = i_addr[2:0];
  assign reg_wr    = sel && !i_rw;
  assign reg_rd    = sel && i_rw;
  assign ctrl_wr   = reg_wr && (idx == 3'd6);
  assign stat_rd   = reg_rd && (idx == 3'd7);
  assign busy      = (state != IDLE);
  assign abort_now = abort_q || (ctrl_wr && i_data[3]);
  assign cnt_view  = 16'(cnt);
  assign o_rden    = reg_rd;
  assign unused_addr_bits = ^{i_addr[15:8], i_addr[4:3]};

`ifdef MMU09_DMA_IRQ_EN
  logic ie_q;

  always_ff @(posedge i_eclk or negedge i_rst_n) begin
    if (!i_rst_n)
      ie_q <= 1'b0;
    else if (ctrl_wr && !busy)
      ie_q <= i_data[7];
  end

  assign ie      = ie_q;
  assign o_irq_n = !(done && ie_q);
`else
  assign ie      = 1'b0;
  assign o_irq_n = 1'b1;
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (idx)
      3'd0: rd_mux = src[15:8];
      3'd1: rd_mux = src[7:0];
      3'd2: rd_mux = dst[15:8];
      3'd3: rd_mux = dst[7:0];
      3'd4: rd_mux = cnt_view[15:8];
      3'd5: rd_mux = cnt_view[7:0];
      3'd6: rd_mux = {ie, 3'b000, abort_q, dstinc, srcinc, 1'b0};
      default: rd_mux = {5'b00000, aborted, done, busy};
    endcase
  end

  always_ff @(posedge i_eclk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Bus outputs decode from state alone so an async reset releases the bus immediately.
  always_comb begin
    state_nx = state;
    o_halt_n = 1'b1;
    o_busen  = 1'b0;
    o_addr   = 16'h0000;
    o_rw     = 1'b1;
    o_data   = reg_rd ? rd_mux : 8'h00;
    case (state)
      IDLE: if (ctrl_wr && i_data[0] && (cnt != '0)) state_nx = REQ;
      REQ: begin
        o_halt_n = 1'b0;
        if (abort_now)
          state_nx = REL;
        else if (i_ba && i_bs)
          state_nx = RD;
      end
      RD: begin
        o_halt_n = 1'b0;
        o_busen  = 1'b1;
        o_addr   = src;
        state_nx = WR;
      end
      WR: begin
        o_halt_n = 1'b0;
        o_busen  = 1'b1;
        o_addr   = dst;
        o_rw     = 1'b0;
        o_data   = rdbuf;
        state_nx = NEXT;
      end
      NEXT: begin
        o_halt_n = 1'b0;
        state_nx = ((cnt == CNT_W'(1)) || abort_now) ? REL : RD;
      end
      REL: if (!i_ba) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Later assignments win: completion beats a same-edge STAT read clear.
  always_ff @(posedge i_eclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src     <= 16'h0000;
      dst     <= 16'h0000;
      cnt     <= '0;
      rdbuf   <= 8'h00;
      srcinc  <= 1'b0;
      dstinc  <= 1'b0;
      abort_q <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (stat_rd) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      if (reg_wr && !busy) begin
        case (idx)
          3'd0: src[15:8] <= i_data;
          3'd1: src[7:0]  <= i_data;
          3'd2: dst[15:8] <= i_data;
          3'd3: dst[7:0]  <= i_data;
          3'd4: cnt <= CNT_W'({i_data, cnt_view[7:0]});
          3'd5: cnt <= CNT_W'({cnt_view[15:8], i_data});
          3'd6: begin
            srcinc  <= i_data[1];
            dstinc  <= i_data[2];
            abort_q <= i_data[3];
            if (i_data[0] && (cnt == '0)) done <= 1'b1;
          end
          default: ;
        endcase
      end
      if (ctrl_wr && busy && i_data[3])
        abort_q <= 1'b1;
      if (state == RD)
        rdbuf <= i_data;
      if (state == NEXT) begin
        cnt <= cnt - CNT_W'(1);
        src <= src + {15'h0000, srcinc};
        dst <= dst + {15'h0000, dstinc};
      end
      if ((state == REL) && !i_ba) begin
        done    <= 1'b1;
        aborted <= abort_q;
        abort_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmu_dma.sv
// tb_mmu_dma: self-checking bench for mmu_dma with a byte-array bus memory, a grant responder
// and a transaction-level copy model.
module tb_mmu_dma;

  logic        i_eclk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_rw = 1'b1;
  logic        i_kernio = 1'b0;
  logic        i_ba = 1'b0;
  logic        i_bs = 1'b0;
  logic [7:0]  i_data;
  logic [7:0]  cpu_data = 8'h00;
  logic        o_halt_n, o_busen, o_rw, o_rden, o_irq_n;
  logic [15:0] o_addr;
  logic [7:0]  o_data;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } xact_t;

  typedef struct {
    logic [15:0] src, dst, cnt;
    logic [7:0]  ctrl;
    int          gdelay;
    logic [7:0]  exp_stat;
  } vec_t;

  logic [7:0] mem [65536];
  logic [7:0] ref_mem [65536];
  xact_t      seen[$];
  xact_t      expq[$];
  vec_t       vecs[7];
  int         checks = 0, errors = 0;
  int         gdelay = 0, hcnt = 0, halt_lo = 0, bus_nogrant = 0, wr_cnt = 0;

  mmu_dma dut (
    .i_eclk(i_eclk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_rw(i_rw), .i_data(i_data),
    .i_kernio(i_kernio), .i_ba(i_ba), .i_bs(i_bs), .o_halt_n(o_halt_n), .o_busen(o_busen),
    .o_addr(o_addr), .o_rw(o_rw), .o_data(o_data), .o_rden(o_rden), .o_irq_n(o_irq_n)
  );

  always #5 i_eclk = ~i_eclk;

  assign i_data = (i_kernio && !i_rw) ? cpu_data : ((o_busen && o_rw) ? mem[o_addr] : 8'h00);

  // Bus side: record DMA cycles, commit writes to memory, and grant the bus gdelay cycles after /HALT.
  always @(negedge i_eclk) begin
    if (!o_halt_n) halt_lo++;
    if (o_busen && !(i_ba && i_bs)) bus_nogrant++;
    if (o_busen) begin
      seen.push_back({o_addr, o_rw, (o_rw ? i_data : o_data)});
      if (!o_rw) begin
        mem[o_addr] = o_data;
        wr_cnt++;
      end
    end
    if (!o_halt_n) begin
      if (hcnt >= gdelay) begin
        i_ba = 1'b1;
        i_bs = 1'b1;
      end else hcnt++;
    end else begin
      i_ba = 1'b0;
      i_bs = 1'b0;
      hcnt = 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_eclk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] idx, input logic [7:0] d);
    i_addr = 16'hFEA0 | 16'(idx);
    i_rw = 1'b0;
    i_kernio = 1'b1;
    cpu_data = d;
    tick();
    i_kernio = 1'b0;
    i_rw = 1'b1;
    i_addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [2:0] idx, output logic [7:0] d, output logic rden);
    i_addr = 16'hFEA0 | 16'(idx);
    i_rw = 1'b1;
    i_kernio = 1'b1;
    #1;
    d = o_data;
    rden = o_rden;
    tick();
    i_kernio = 1'b0;
    i_addr = 16'h0000;
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [7:0] exp);
    logic [7:0] d;
    logic r;
    cpu_read(idx, d, r);
    check_output(name, 32'(d), 32'(exp));
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    cpu_write(3'd0, s[15:8]);
    cpu_write(3'd1, s[7:0]);
    cpu_write(3'd2, d[15:8]);
    cpu_write(3'd3, d[7:0]);
    cpu_write(3'd4, c[15:8]);
    cpu_write(3'd5, c[7:0]);
  endtask

  // Reference copy: byte i reads src+i*SRCINC then writes it to dst+i*DSTINC, 16-bit wrap.
  task automatic build_model(input vec_t v, input int nbytes, output logic [15:0] s_end, output logic [15:0] d_end);
    logic [15:0] s, d;
    logic [7:0] b;
    s = v.src;
    d = v.dst;
    expq.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = ref_mem[s];
      expq.push_back({s, 1'b1, b});
      expq.push_back({d, 1'b0, b});
      ref_mem[d] = b;
      if (v.ctrl[1]) s = s + 16'd1;
      if (v.ctrl[2]) d = d + 16'd1;
    end
    s_end = s;
    d_end = d;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    tick();
    while (!(o_halt_n && !i_ba) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_output({name, "_timeout"}, 32'(n), 32'(0));
    tick();
  endtask

  task automatic compare_bus(input string name);
    check_output({name, "_nxact"}, 32'(seen.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < seen.size()) check_output($sformatf("%s_xact%0d", name, i), 32'(seen[i]), 32'(expq[i]));
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    logic [15:0] s_end, d_end;
    ref_mem = mem;
    build_model(v, int'(v.cnt), s_end, d_end);
    program_regs(v.src, v.dst, v.cnt);
    seen.delete();
    halt_lo = 0;
    gdelay = v.gdelay;
    cpu_write(3'd6, v.ctrl);
    cpu_write(3'd1, 8'hA5);
    wait_done(name, 200);
    compare_bus(name);
    check_output({name, "_halt_cycles"}, 32'(halt_lo), 32'(v.gdelay + 1 + 3 * int'(v.cnt)));
    check_output({name, "_halt_n"}, 32'(o_halt_n), 32'(1));
    check_reg({name, "_srchi"}, 3'd0, s_end[15:8]);
    check_reg({name, "_srclo"}, 3'd1, s_end[7:0]);
    check_reg({name, "_dsthi"}, 3'd2, d_end[15:8]);
    check_reg({name, "_dstlo"}, 3'd3, d_end[7:0]);
    check_reg({name, "_cntlo"}, 3'd5, 8'h00);
    check_reg({name, "_ctrl"}, 3'd6, {5'b00000, v.ctrl[2:1], 1'b0});
    check_reg({name, "_stat"}, 3'd7, v.exp_stat);
    check_reg({name, "_stat2"}, 3'd7, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic r;
    logic [15:0] s_end, d_end;
    int n;
    vec_t v;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    vecs[0] = '{16'h1000, 16'h2000, 16'd3, 8'h07, 2, 8'h02};
    vecs[1] = '{16'hFE40, 16'h3000, 16'd4, 8'h01, 0, 8'h02};
    vecs[2] = '{16'h4000, 16'hFFFF, 16'd2, 8'h05, 1, 8'h02};
    for (int i = 3; i < 7; i++)
      vecs[i] = '{16'($urandom), 16'($urandom), 16'($urandom_range(1, 6)),
                  8'h01 | 8'($urandom_range(0, 3) << 1), $urandom_range(0, 3), 8'h02};

    #2;
    check_output("rst_halt_n", 32'(o_halt_n), 32'(1));
    check_output("rst_busen", 32'(o_busen), 32'(0));
    check_output("rst_rw", 32'(o_rw), 32'(1));
    check_output("rst_addr", 32'(o_addr), 32'(0));
    check_output("rst_data", 32'(o_data), 32'(0));
    check_output("rst_rden", 32'(o_rden), 32'(0));
    check_output("rst_irq_n", 32'(o_irq_n), 32'(1));
    #10 i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Zero count: DONE at once, no bus request.
    program_regs(16'h1234, 16'h5678, 16'h0000);
    halt_lo = 0;
    cpu_write(3'd6, 8'h01);
    check_output("cnt0_halt_n", 32'(o_halt_n), 32'(1));
    tick();
    tick();
    check_output("cnt0_halt_cycles", 32'(halt_lo), 32'(0));
    cpu_read(3'd7, d, r);
    check_output("cnt0_stat", 32'(d), 32'h02);
    check_output("cnt0_rden", 32'(r), 32'(1));
    check_reg("cnt0_stat2", 3'd7, 8'h00);

    // Abort during the second WR of a five-byte copy.
    v = '{16'h5000, 16'h6000, 16'd5, 8'h07, 1, 8'h06};
    ref_mem = mem;
    build_model(v, 2, s_end, d_end);
    program_regs(v.src, v.dst, v.cnt);
    seen.delete();
    wr_cnt = 0;
    gdelay = v.gdelay;
    cpu_write(3'd6, v.ctrl);
    n = 0;
    while (!(o_busen && !o_rw && wr_cnt == 1) && n < 100) begin
      tick();
      n++;
    end
    check_output("abort_reach_wr2", 32'(n < 100), 32'(1));
    cpu_write(3'd6, 8'h0E);
    wait_done("abort", 100);
    check_output("abort_writes", 32'(wr_cnt), 32'(2));
    compare_bus("abort");
    check_output("abort_halt_n", 32'(o_halt_n), 32'(1));
    check_reg("abort_cnthi", 3'd4, 8'h00);
    check_reg("abort_cntlo", 3'd5, 8'h03);
    check_reg("abort_srclo", 3'd1, s_end[7:0]);
    check_reg("abort_stat", 3'd7, 8'h06);

    // Completion interrupt with CTRL b7 set.
    program_regs(16'h0100, 16'h0200, 16'h0001);
    cpu_write(3'd6, 8'h87);
    wait_done("irq", 100);
`ifdef MMU09_DMA_IRQ_EN
    check_output("irq_low", 32'(o_irq_n), 32'(0));
    check_reg("irq_ctrl", 3'd6, 8'h86);
`else
    check_output("irq_tied", 32'(o_irq_n), 32'(1));
    check_reg("irq_ctrl", 3'd6, 8'h06);
`endif
    check_reg("irq_stat", 3'd7, 8'h02);
    check_output("irq_cleared", 32'(o_irq_n), 32'(1));

    // Reset asserted while the engine is in RD.
    program_regs(16'h7000, 16'h7100, 16'h0004);
    gdelay = 0;
    cpu_write(3'd6, 8'h07);
    n = 0;
    while (!(o_busen && o_rw) && n < 50) begin
      tick();
      n++;
    end
    check_output("rstmid_reach_rd", 32'(n < 50), 32'(1));
    i_rst_n = 1'b0;
    #1;
    check_output("rstmid_busen", 32'(o_busen), 32'(0));
    check_output("rstmid_halt_n", 32'(o_halt_n), 32'(1));
    check_output("rstmid_addr", 32'(o_addr), 32'(0));
    #2 i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) check_reg($sformatf("rstmid_reg%0d", i), 3'(i), 8'h00);

    check_output("bus_without_grant", 32'(bus_nogrant), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
